// File: rtl/dmem_pkg.sv
// Shared types and constants for the sized data memory.
//   dmem_size_e  : request size encoding (byte/half/word/doubleword)
//   dmem_state_e : controller FSM states
//   Bytes*       : byte count per access size, plus size_bytes() lookup
package dmem_pkg;

    typedef enum logic [1:0] {
        SizeByte   = 2'b00,
        SizeHalf   = 2'b01,
        SizeWord   = 2'b10,
        SizeDouble = 2'b11
    } dmem_size_e;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StResp
    } dmem_state_e;

    localparam logic [3:0] BytesByte   = 4'd1;
    localparam logic [3:0] BytesHalf   = 4'd2;
    localparam logic [3:0] BytesWord   = 4'd4;
    localparam logic [3:0] BytesDouble = 4'd8;

    function automatic logic [3:0] size_bytes(input dmem_size_e size);
        logic [3:0] n;
        n = BytesByte;
        unique case (size)
            SizeByte:   n = BytesByte;
            SizeHalf:   n = BytesHalf;
            SizeWord:   n = BytesWord;
            SizeDouble: n = BytesDouble;
            default:    n = BytesByte;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for one memory access.
// Ports:
//   size_i, signed_i, offset_i : access size, load extension mode, byte offset in word
//   wdata_i                    : right-justified store data
//   rword_i                    : full memory word at the addressed index
//   strb_o                     : byte-lane write strobes (all zero on fault)
//   wdata_o                    : store data shifted into its lanes
//   rdata_o                    : extracted, right-justified, extended load data (0 on fault)
//   fault_o                    : misaligned access or size wider than the word
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumBytes  = DataWidth / 8,
    parameter int unsigned OffWidth  = $clog2(DataWidth / 8)
) (
    input  logic [1:0]           size_i,
    input  logic                 signed_i,
    input  logic [OffWidth-1:0]  offset_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [DataWidth-1:0] rword_i,
    output logic [NumBytes-1:0]  strb_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 fault_o
);

    dmem_size_e           size;
    logic [3:0]           nbytes;
    logic [3:0]           off_ext;
    logic                 fault;
    logic                 sign_bit;
    logic [DataWidth-1:0] shifted;
    logic [DataWidth-1:0] mask;

    assign size    = dmem_size_e'(size_i);
    assign nbytes  = size_bytes(size);
    assign off_ext = 4'(offset_i);

    // Sizes are powers of two, so (nbytes - 1) masks the offset bits that must be zero.
    assign fault   = (nbytes > 4'(NumBytes)) || ((off_ext & (nbytes - 4'd1)) != 4'd0);
    assign fault_o = fault;

    always_comb begin
        wdata_o  = wdata_i << {offset_i, 3'b000};
        shifted  = rword_i >> {offset_i, 3'b000};
        strb_o   = '0;
        mask     = '0;
        sign_bit = 1'b0;

        for (int i = 0; i < int'(NumBytes); i++) begin
            strb_o[i]      = !fault && (4'(i) >= off_ext) && (4'(i) < off_ext + nbytes);
            mask[8*i +: 8] = {8{4'(i) < nbytes}};
        end

        unique case (size)
            SizeByte: sign_bit = shifted[7];
            SizeHalf: sign_bit = shifted[15];
            SizeWord: sign_bit = shifted[31];
            default:  sign_bit = shifted[DataWidth-1];
        endcase

        rdata_o = (shifted & mask) | ({DataWidth{signed_i & sign_bit}} & ~mask);
        if (fault) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed little-endian data memory with sized, optionally sign-extended loads.
// One request accepted per cycle; each acceptance produces a one-cycle response pulse
// on the following cycle. Store responses return data 0.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid_in / req_ready_out   : request handshake
//   req_write_in, req_size_in,
//   req_signed_in, addr_in,
//   write_data_in                  : request fields
//   rsp_valid_out, read_data_out,
//   fault_out                      : response (data/fault held between responses)
// Build option: DMEM_INIT_CLEAR_EN -- after reset, zero every word (one per cycle)
// with ready held low; without it memory contents after reset are undefined.
module sized_data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_write_in,
    input  logic [1:0]            req_size_in,
    input  logic                  req_signed_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    output logic                  rsp_valid_out,
    output logic [DATA_WIDTH-1:0] read_data_out,
    output logic                  fault_out
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned OffWidth = $clog2(NumBytes);
    localparam int unsigned IdxWidth = ADDR_WIDTH - OffWidth;
    localparam int unsigned Depth    = 1 << IdxWidth;

`ifdef DMEM_INIT_CLEAR_EN
    localparam dmem_state_e ResetState = StInit;
`else
    localparam dmem_state_e ResetState = StIdle;
`endif

    dmem_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  fault_q;

    logic                  accept;
    logic                  store_we;
    logic [IdxWidth-1:0]   word_idx;
    logic [OffWidth-1:0]   byte_off;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [NumBytes-1:0]   strb;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  fault;

    assign word_idx = addr_in[ADDR_WIDTH-1:OffWidth];
    assign byte_off = addr_in[OffWidth-1:0];
    assign rd_word  = mem_q[word_idx];
    assign accept   = req_valid_in && req_ready_out && !rst;
    assign store_we = accept && req_write_in;

    dmem_lane_align #(
        .DataWidth (DATA_WIDTH)
    ) u_lane_align (
        .size_i   (req_size_in),
        .signed_i (req_signed_in),
        .offset_i (byte_off),
        .wdata_i  (write_data_in),
        .rword_i  (rd_word),
        .strb_o   (strb),
        .wdata_o  (wdata_sh),
        .rdata_o  (load_data),
        .fault_o  (fault)
    );

`ifdef DMEM_INIT_CLEAR_EN
    logic [IdxWidth-1:0] sweep_q, sweep_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_q <= '0;
        end else begin
            sweep_q <= sweep_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready_out = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
        sweep_d       = sweep_q;
`endif
        unique case (state_q)
            StInit: begin
`ifdef DMEM_INIT_CLEAR_EN
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IdxWidth'(Depth - 1)) begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            StIdle: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                req_ready_out = 1'b1;
                state_d       = req_valid_in ? StResp : StIdle;
            end
            default: state_d = ResetState;
        endcase
    end

    // No reset on the array; during the sweep ready is low, so stores cannot collide.
    always_ff @(posedge clk) begin
`ifdef DMEM_INIT_CLEAR_EN
        if (!rst && state_q == StInit) begin
            mem_q[sweep_q] <= '0;
        end else
`endif
        if (store_we) begin
            for (int i = 0; i < int'(NumBytes); i++) begin
                if (strb[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    // Load data is captured at the acceptance edge from the pre-write array contents,
    // which already include any store accepted on an earlier cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
            fault_q     <= 1'b0;
        end else if (accept) begin
            read_data_q <= req_write_in ? '0 : load_data;
            fault_q     <= fault;
        end
    end

    assign rsp_valid_out = (state_q == StResp);
    assign read_data_out = read_data_q;
    assign fault_out     = fault_q;

endmodule

// File: doc/sized_data_memory.md
SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, byte-address width; depth = 2^ADDR_WIDTH / (DATA_WIDTH/8) words.
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have req_valid_in  input  1  request present.
REQ-006 SHALL have req_ready_out  output  1  request accepted when both valid and ready are high.
REQ-007 SHALL have req_write_in  input  1  1 = store, 0 = load.
REQ-008 SHALL have req_size_in  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-009 SHALL have req_signed_in  input  1  load sign-extends when 1, zero-extends when 0.
REQ-010 SHALL have addr_in  input  ADDR_WIDTH  byte address, little-endian.
REQ-011 SHALL have write_data_in  input  DATA_WIDTH  store data, right-justified.
REQ-012 SHALL have rsp_valid_out  output  1  one-cycle response pulse.
REQ-013 SHALL have read_data_out  output  DATA_WIDTH  load result, right-justified and extended.
REQ-014 SHALL have fault_out  output  1  qualified by rsp_valid_out; access rejected.

Function
REQ-015 SHALL implement FSM states INIT, IDLE, RESP; IDLE->RESP on acceptance; RESP->RESP on acceptance, else ->IDLE.
REQ-016 SHALL drive req_ready_out high in IDLE and RESP, low in INIT, giving one accepted request per cycle.
REQ-017 SHALL assert rsp_valid_out exactly one cycle after each acceptance, for loads and stores.
REQ-018 SHALL hold read_data_out and fault_out stable between responses.
REQ-019 SHALL on store, write only the byte lanes selected by size and addr offset; other lanes unchanged.
REQ-020 SHALL on load, register the selected lanes at acceptance edge, shift to bit 0 and extend per req_signed_in.
REQ-021 SHALL return read_data_out = 0 for store responses.
REQ-022 SHALL flag fault when addr offset is not a multiple of access size, or size is 11 with DATA_WIDTH=32; faulting store writes nothing, faulting load returns 0.
REQ-023 SHALL make a store visible to a load accepted the following cycle (no stale read).

Reset
REQ-024 SHALL on rst clear rsp_valid_out, fault_out and read_data_out to 0 and enter INIT (macro on) or IDLE (macro off).
REQ-025 SHALL on rst during any state, including mid-INIT, discard in-flight response and restart from REQ-024.

Configuration
REQ-026 SHALL, with DMEM_INIT_CLEAR_EN defined, sweep all words to zero in INIT, one word per cycle from word 0, ready low for exactly depth cycles, then enter IDLE.
REQ-027 SHALL, without DMEM_INIT_CLEAR_EN, omit INIT and sweep counter; memory contents after reset undefined; ready high first cycle after rst falls.

Structure
REQ-028 SHALL place size encoding enum, FSM state enum and size-to-byte-count constants in package dmem_pkg.
REQ-029 SHALL use one combinational sub-module dmem_lane_align producing byte strobes, store-lane shift, load extraction/extension and misalign fault.

Verification (DATA_WIDTH=32, ADDR_WIDTH=6)
REQ-030 SHALL check word store 0xDEADBEEF @0x10 then word load @0x10 -> rsp next cycle, data 0xDEADBEEF, fault 0.
REQ-031 SHALL check byte store 0x80 @0x11 then word load @0x10 -> 0xDEAD80EF; signed byte load @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-032 SHALL check half store @0x13 and half load @0x13 -> fault 1, data 0, word @0x10 unchanged; size 11 -> fault 1.
REQ-033 SHALL check back-to-back store 0x12345678 @0x20 then load @0x20 next cycle -> 0x12345678; continuous valid yields rsp every cycle.
REQ-034 SHALL check with DMEM_INIT_CLEAR_EN: ready low 16 cycles after reset, then any load -> 0; rst at sweep cycle 5 -> ready low full 16 cycles again.
